// File: rtl/cache_miss_tracker_pkg.sv
// cache_miss_tracker_pkg: entry types and default geometry shared by the miss tracker files.
package cache_miss_tracker_pkg;
    localparam int MT_ENTRIES = 4;
    localparam int MT_WAYS = 4;
    localparam int MT_ADDR_W = 32;
    localparam int MT_BLOCK = 32;
    localparam int MT_ID_W = 3;
    typedef enum logic [1:0] {FREE, MISS, ALLOC, RESP} miss_entry_state_t;
    typedef enum logic [1:0] {REQ, WAIT, DONE} fetch_phase_t;
    typedef struct packed {
        miss_entry_state_t state;
        fetch_phase_t phase;
        logic wb_pend;
        logic [MT_ADDR_W-1:0] block_addr;
        logic [MT_ID_W-1:0] req_id;
        logic [MT_WAYS-1:0] victim_way;
    } miss_entry_t;
endpackage

// File: rtl/cache_miss_tracker_if.sv
// cache_miss_tracker_if: miss intake, writeback, fetch, allocate and response ports of the miss tracker.
interface cache_miss_tracker_if #(
    parameter int NUM_ENTRIES = 4,
    parameter int NUM_WAYS = 4,
    parameter int ADDRESS_WIDTH = 32,
    parameter int REQ_ID = 3
);
    localparam int TAG_W = $clog2(NUM_ENTRIES);
    logic miss_valid, miss_ready, miss_victim_dirty;
    logic [ADDRESS_WIDTH-1:0] miss_block_addr, fetch_address, alloc_address;
    logic [REQ_ID-1:0] miss_req_id, resp_req_id;
    logic [NUM_WAYS-1:0] miss_victim_way, wb_way, alloc_way, resp_way;
    logic wb_request, wb_done, fetch_request, fetch_ack, line_fill_valid;
    logic [TAG_W-1:0] fetch_tag, line_fill_tag;
    logic alloc_request, alloc_ack, resp_valid, resp_ready, fill_error;
    modport slave (
        input miss_valid, miss_block_addr, miss_req_id, miss_victim_way, miss_victim_dirty,
        input wb_done, fetch_ack, line_fill_valid, line_fill_tag, alloc_ack, resp_ready,
        output miss_ready, wb_request, wb_way, fetch_request, fetch_address, fetch_tag,
        output alloc_request, alloc_way, alloc_address, resp_valid, resp_req_id, resp_way, fill_error
    );
    modport master (
        output miss_valid, miss_block_addr, miss_req_id, miss_victim_way, miss_victim_dirty,
        output wb_done, fetch_ack, line_fill_valid, line_fill_tag, alloc_ack, resp_ready,
        input miss_ready, wb_request, wb_way, fetch_request, fetch_address, fetch_tag,
        input alloc_request, alloc_way, alloc_address, resp_valid, resp_req_id, resp_way, fill_error
    );
endinterface

// File: rtl/cache_miss_tracker_entry.sv
// cache_miss_tracker_entry: one outstanding miss slot stepping FREE -> MISS -> ALLOC -> RESP -> FREE.
module cache_miss_tracker_entry import cache_miss_tracker_pkg::*; (
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  miss_entry_t init,
    input  logic        wb_done,
    input  logic        fetch_ack,
    input  logic        fill,
    input  logic        alloc_ack,
    input  logic        resp_ack,
    output miss_entry_t ent
);
    miss_entry_t nxt;
    always_comb begin
        nxt = ent;
        if (ent.state == FREE && accept) nxt = init;
        if (ent.state == MISS) begin
            if (wb_done) nxt.wb_pend = 1'b0;
            if (fetch_ack) nxt.phase = WAIT;
            if (fill) nxt.phase = DONE;
            // a writeback and fill finishing on the same edge both land before the ALLOC test
            if (!nxt.wb_pend && nxt.phase == DONE) nxt.state = ALLOC;
        end
        if (ent.state == ALLOC && alloc_ack) nxt.state = RESP;
        if (ent.state == RESP && resp_ack) nxt.state = FREE;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) ent <= '0;
        else ent <= nxt;
endmodule

// File: rtl/cache_miss_tracker.sv
// cache_miss_tracker: up to NUM_ENTRIES concurrent misses with lowest-index arbitration on each shared port.
// Define CACHE_MISS_TRACKER_WB_OVERLAP_EN to let a fetch issue while its victim writeback is still pending.
module cache_miss_tracker import cache_miss_tracker_pkg::*; #(
    parameter int NUM_ENTRIES = MT_ENTRIES,
    parameter int NUM_WAYS = MT_WAYS,
    parameter int ADDRESS_WIDTH = MT_ADDR_W,
    parameter int BLOCK_SIZE = MT_BLOCK,
    parameter int REQ_ID = MT_ID_W
) (
    input logic clk,
    input logic reset,
    cache_miss_tracker_if.slave bus
);
    localparam int OFFSET = $clog2(BLOCK_SIZE);
    localparam int TAG_W = $clog2(NUM_ENTRIES);
    localparam int NP = 5;  // ports: writeback, fetch, alloc, resp, plus free-slot select
`ifdef CACHE_MISS_TRACKER_WB_OVERLAP_EN
    localparam bit WB_OVERLAP = 1'b1;
`else
    localparam bit WB_OVERLAP = 1'b0;
`endif
    miss_entry_t ent [NUM_ENTRIES];
    miss_entry_t init;
    logic [NUM_ENTRIES-1:0] cand [NP];
    logic [TAG_W-1:0] low_i [NP];
    logic [TAG_W-1:0] gnt_i [NP];
    logic [TAG_W-1:0] lk_i [NP];
    logic [NP-1:0] ack, gnt_v, lk_v;
    logic [NUM_ENTRIES-1:0] conflict, fill_hit;
    logic rdy_en, fill_error, miss_ready, accept;
    assign init = '{state: MISS, phase: REQ, wb_pend: bus.miss_victim_dirty, block_addr: bus.miss_block_addr,
                    req_id: REQ_ID'(bus.miss_req_id), victim_way: NUM_WAYS'(bus.miss_victim_way)};
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cand[0][i] = ent[i].state == MISS && ent[i].wb_pend;
            cand[1][i] = ent[i].state == MISS && ent[i].phase == REQ && (WB_OVERLAP || !ent[i].wb_pend);
            cand[2][i] = ent[i].state == ALLOC;
            cand[3][i] = ent[i].state == RESP;
            cand[4][i] = ent[i].state == FREE;
            conflict[i] = ent[i].state != FREE &&
                (ent[i].block_addr[ADDRESS_WIDTH-1:OFFSET] == bus.miss_block_addr[ADDRESS_WIDTH-1:OFFSET] ||
                 |(ent[i].victim_way & bus.miss_victim_way));
            fill_hit[i] = bus.line_fill_valid && bus.line_fill_tag == TAG_W'(i) &&
                ent[i].state == MISS && ent[i].phase == WAIT;
        end
    end
    // a granted entry stays locked on its port until acked, so requests never switch mid-handshake
    always_comb begin
        for (int p = 0; p < NP; p++) begin
            low_i[p] = '0;
            for (int i = NUM_ENTRIES - 1; i >= 0; i--)
                if (cand[p][i]) low_i[p] = TAG_W'(i);
            gnt_v[p] = lk_v[p] || |cand[p];
            gnt_i[p] = lk_v[p] ? lk_i[p] : low_i[p];
        end
    end
    assign ack = {1'b1, bus.resp_ready, bus.alloc_ack, bus.fetch_ack, bus.wb_done};
    assign miss_ready = rdy_en && |cand[4] && !(|conflict);
    assign accept = bus.miss_valid && miss_ready;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            lk_v <= '0;
            for (int p = 0; p < NP; p++) lk_i[p] <= '0;
            rdy_en <= 1'b0;
            fill_error <= 1'b0;
        end else begin
            lk_v <= gnt_v & ~ack;
            for (int p = 0; p < NP; p++) lk_i[p] <= gnt_i[p];
            rdy_en <= 1'b1;
            fill_error <= fill_error || (bus.line_fill_valid && !(|fill_hit));
        end
    for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_ent
        cache_miss_tracker_entry u_ent (
            .clk,
            .reset,
            .accept(accept && gnt_i[4] == TAG_W'(k)),
            .init,
            .wb_done(bus.wb_done && gnt_v[0] && gnt_i[0] == TAG_W'(k)),
            .fetch_ack(bus.fetch_ack && gnt_v[1] && gnt_i[1] == TAG_W'(k)),
            .fill(fill_hit[k]),
            .alloc_ack(bus.alloc_ack && gnt_v[2] && gnt_i[2] == TAG_W'(k)),
            .resp_ack(bus.resp_ready && gnt_v[3] && gnt_i[3] == TAG_W'(k)),
            .ent(ent[k])
        );
    end
    assign bus.miss_ready = miss_ready;
    assign bus.wb_request = gnt_v[0];
    assign bus.wb_way = gnt_v[0] ? ent[gnt_i[0]].victim_way : '0;
    assign bus.fetch_request = gnt_v[1];
    assign bus.fetch_address = gnt_v[1] ? ent[gnt_i[1]].block_addr : '0;
    assign bus.fetch_tag = gnt_v[1] ? gnt_i[1] : '0;
    assign bus.alloc_request = gnt_v[2];
    assign bus.alloc_way = gnt_v[2] ? ent[gnt_i[2]].victim_way : '0;
    assign bus.alloc_address = gnt_v[2] ? ent[gnt_i[2]].block_addr : '0;
    assign bus.resp_valid = gnt_v[3];
    assign bus.resp_req_id = gnt_v[3] ? ent[gnt_i[3]].req_id : '0;
    assign bus.resp_way = gnt_v[3] ? ent[gnt_i[3]].victim_way : '0;
    assign bus.fill_error = fill_error;
endmodule
